// File: rtl/stepper_seq_driver.sv
// Stepper-motor sequencer for 4-coil PmodSTEP outputs: wave, full-step and half-step drive,
// a programmed number of steps at a programmable period, then a one-cycle done pulse.
module stepper_seq_driver #(
    parameter int unsigned CNT_W = 11,
    parameter int unsigned DIV_W = 20,
    parameter bit          HOLD  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] period,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_WAVE = 2'd0;
    localparam logic [1:0] MODE_HALF = 2'd2;

    state_t           state_q, state_d;
    logic [2:0]       index_q, index_d;
    logic [3:0]       coil_q, coil_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             half_q, half_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    logic [3:0]       idle_coil;
    logic [2:0]       aligned_index;
    logic [2:0]       step_size;
    logic [2:0]       next_index;

    function automatic logic [3:0] phase(input logic [2:0] idx);
        logic [3:0] pattern;
        case (idx)
            3'd0:    pattern = 4'b0001;
            3'd1:    pattern = 4'b0011;
            3'd2:    pattern = 4'b0010;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0100;
            3'd5:    pattern = 4'b1100;
            3'd6:    pattern = 4'b1000;
            default: pattern = 4'b1001;
        endcase
        return pattern;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        coil_d      = coil_q;
        div_d       = div_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        half_d      = half_q;
        dir_d       = dir_q;
        done_d      = 1'b0;

        idle_coil = HOLD ? coil_q : 4'b0000;

        // Wave lives on even indices, full (and mode 3) on odd ones, half anywhere.
        case (mode)
            MODE_WAVE: aligned_index = {index_q[2:1], 1'b0};
            MODE_HALF: aligned_index = index_q;
            default:   aligned_index = {index_q[2:1], 1'b1};
        endcase

        step_size  = half_q ? 3'd1 : 3'd2;
        next_index = dir_q ? (index_q - step_size) : (index_q + step_size);

        case (state_q)
            S_IDLE: begin
                coil_d = idle_coil;
                if (start) begin
                    remaining_d = steps;
                    if (steps != '0) begin
                        state_d  = S_RUN;
                        dir_d    = dir;
                        half_d   = (mode == MODE_HALF);
                        period_d = (period == '0) ? DIV_W'(1) : period;
                        div_d    = '0;
                        index_d  = aligned_index;
                        coil_d   = phase(aligned_index);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    coil_d  = idle_coil;
                end else if (div_q == period_q - DIV_W'(1)) begin
                    div_d       = '0;
                    index_d     = next_index;
                    coil_d      = phase(next_index);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            coil_q      <= '0;
            div_q       <= '0;
            period_q    <= DIV_W'(1);
            remaining_q <= '0;
            half_q      <= 1'b0;
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            coil_q      <= coil_d;
            div_q       <= div_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            half_q      <= half_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
        end
    end

    assign coil      = coil_q;
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_stepper_seq_driver.sv
// Bench for stepper_seq_driver: directed vector table, hand-written corner sequences and
// random stimulus, all checked against a cycle-level behavioural model of the motor position.
module tb_stepper_seq_driver;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned DIV_W = 20;
    localparam bit          HOLD  = 1'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             dir;
    logic [1:0]       mode;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] period;
    logic [3:0]       coil;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    stepper_seq_driver #(.CNT_W(CNT_W), .DIV_W(DIV_W), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
        .steps(steps), .period(period), .coil(coil), .busy(busy), .done(done),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0100, 4'b1100, 4'b1000, 4'b1001};

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: motor position, run bookkeeping, expected outputs.
    int         m_pos, m_per, m_rem, m_elapsed, m_inc;
    bit         m_busy, m_done, m_dir;
    logic [3:0] m_coil;

    typedef struct {
        logic [1:0] mode;
        logic       dir;
        int         steps;
        int         period;
        logic [3:0] first_coil;
        logic [3:0] last_coil;
        int         cycles;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pos = 0; m_per = 1; m_rem = 0; m_elapsed = 0; m_inc = 2;
        m_busy = 0; m_done = 0; m_dir = 0; m_coil = 4'b0000;
    endtask

    task automatic model_step();
        int base;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            m_done = 0;
            m_coil = HOLD ? m_coil : 4'b0000;
            if (start) begin
                m_rem = int'(steps);
                if (steps != 0) begin
                    m_busy    = 1;
                    m_dir     = dir;
                    m_inc     = (mode == 2) ? 1 : 2;
                    m_per     = (period == 0) ? 1 : int'(period);
                    m_elapsed = 0;
                    base      = m_pos - (m_pos % 2);
                    if (mode == 0)      m_pos = base;
                    else if (mode != 2) m_pos = base + 1;
                    m_coil = tbl[m_pos];
                end else begin
                    m_done = 1;
                end
            end
        end else begin
            m_done = 0;
            if (stop) begin
                m_busy = 0;
                m_coil = HOLD ? m_coil : 4'b0000;
            end else begin
                m_elapsed++;
                if (m_elapsed % m_per == 0) begin
                    m_pos  = (m_pos + (m_dir ? -m_inc : m_inc) + 8) % 8;
                    m_coil = tbl[m_pos];
                    m_rem--;
                    if (m_rem == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        check("model_coil", coil, m_coil);
        check("model_busy", busy, m_busy);
        check("model_done", done, m_done);
        check("model_remaining", remaining, m_rem);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 5000) begin
            cycle();
            n++;
        end
        if (busy) check({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{2'd1, 1'b0, 4,    3, 4'b0011, 4'b0011, 12};
        vecs[1] = '{2'd2, 1'b0, 2,    1, 4'b0011, 4'b0110, 2};
        vecs[2] = '{2'd0, 1'b0, 3,    2, 4'b0010, 4'b0001, 6};
        vecs[3] = '{2'd2, 1'b1, 3,    1, 4'b0001, 4'b1100, 3};
        vecs[4] = '{2'd3, 1'b1, 2,    0, 4'b1100, 4'b0011, 2};
        vecs[5] = '{2'd0, 1'b1, 1,    4, 4'b0001, 4'b1000, 4};
        vecs[6] = '{2'd2, 1'b0, 2047, 1, 4'b1000, 4'b1100, 2047};

        rst = 1'b1; start = 0; stop = 0; dir = 0; mode = 0; steps = 0; period = 0;
        model_reset();
        cycle();
        cycle();
        check("reset_coil", coil, 4'b0000);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_remaining", remaining, 0);
        rst = 1'b0;
        cycle();

        foreach (vecs[i]) begin
            mode = vecs[i].mode; dir = vecs[i].dir;
            steps = CNT_W'(vecs[i].steps); period = DIV_W'(vecs[i].period);
            start = 1'b1;
            cycle();
            start = 1'b0;
            check("vec_first_coil", coil, vecs[i].first_coil);
            check("vec_busy_on_start", busy, 1);
            n = 0;
            while (busy && n < 5000) begin
                cycle();
                n++;
            end
            check("vec_run_len", n, vecs[i].cycles);
            check("vec_last_coil", coil, vecs[i].last_coil);
            check("vec_done_at_end", done, 1);
            check("vec_remaining_end", remaining, 0);
            cycle();
            check("vec_done_width", done, 0);
            check("vec_idle_coil", coil, 4'b0000);
        end

        // Stop on the edge where step 2 falls due (position 5 -> wave aligns to 4).
        mode = 2'd0; dir = 0; steps = 5; period = 10; start = 1'b1;
        cycle();
        start = 1'b0;
        check("stop_first_coil", coil, 4'b0100);
        repeat (19) cycle();
        check("stop_step1_coil", coil, 4'b1000);
        check("stop_step1_remaining", remaining, 4);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        check("stop_remaining", remaining, 4);
        check("stop_coil", coil, 4'b0000);
        cycle();
        check("stop_no_late_done", done, 0);

        // Zero-step start: done pulses next cycle, no motion.
        mode = 2'd1; steps = 0; period = 3; start = 1'b1;
        cycle();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_coil", coil, 4'b0000);
        cycle();
        check("zero_done_width", done, 0);

        // Start while busy is ignored.
        mode = 2'd2; dir = 0; steps = 3; period = 5; start = 1'b1;
        cycle();
        start = 1'b0;
        check("busy_first_coil", coil, 4'b1000);
        cycle();
        cycle();
        steps = 9; start = 1'b1;
        cycle();
        start = 1'b0;
        check("busy_start_ignored_rem", remaining, 3);
        check("busy_start_ignored_busy", busy, 1);
        wait_idle("busy_run");
        check("busy_run_done", done, 1);

        // Back-to-back start in the cycle right after done (position 1 -> wave aligns to 0).
        mode = 2'd0; dir = 0; steps = 2; period = 1; start = 1'b1;
        cycle();
        start = 1'b0;
        check("b2b_accept", busy, 1);
        check("b2b_coil", coil, 4'b0001);
        wait_idle("b2b_run");

        // Asynchronous reset mid-run.
        mode = 2'd1; steps = 10; period = 3; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_coil", coil, 4'b0000);
        check("async_busy", busy, 0);
        check("async_remaining", remaining, 0);
        compare_model();
        cycle();
        rst = 1'b0;
        mode = 2'd1; dir = 0; steps = 1; period = 1; start = 1'b1;
        cycle();
        start = 1'b0;
        check("post_reset_coil", coil, 4'b0011);
        cycle();
        check("post_reset_done", done, 1);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom % 6) == 0;
            stop   = ($urandom % 20) == 0;
            dir    = 1'($urandom);
            mode   = 2'($urandom);
            steps  = (($urandom % 16) == 0) ? CNT_W'($urandom % 40) : CNT_W'($urandom % 8);
            period = DIV_W'($urandom % 4);
            cycle();
        end
        start = 0; stop = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stepper_seq_driver.md
# stepper_seq_driver

Parametrised stepper-motor sequencer for 4-coil PmodSTEP outputs. It supports wave, two-phase full-step and half-step drive. It runs a programmed number of steps in either direction at a programmable step period, then reports completion. It sits between the kitchen-helper control FSM, which issues start/stop commands, and the PmodSTEP pins, and it replaces the fixed-rate, free-running full-step driver.

## Interface
Parameters:
- CNT_W, 11: width of step-count input and remaining-count output (400 steps/rev fits).
- DIV_W, 20: width of step-period divider.
- HOLD, 0: 1 keeps the last coil pattern energised while idle; 0 drives 4'b0000 when idle.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- stop  in  1  abort request; sampled only in RUN.
- dir  in  1  0 = forward (index increments), 1 = reverse (index decrements); latched at start.
- mode  in  2  0 = wave, 1 = full (two-phase), 2 = half-step, 3 = treated as full; latched at start.
- steps  in  CNT_W  number of steps to execute; latched at start.
- period  in  DIV_W  clk cycles per step; latched at start; 0 is treated as 1.
- coil  out  4  registered PmodSTEP coil drive.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on normal completion.
- remaining  out  CNT_W  steps still to execute.

## Operation
- Phase table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Wave mode uses even indices only, full mode uses odd indices only, and half mode uses all indices.
- Step increment: ±1 in half mode, ±2 otherwise. Index arithmetic is 3-bit modulo 8, so wrap is 7→0 forward and 0→7 reverse.
- FSM states:
  - IDLE, start=1, steps≠0 → RUN. Latch dir, mode, steps, period; clear divider to 0.
  - Alignment on that transition: wave clears index bit0; full sets index bit0; half leaves the index unchanged.
  - IDLE, start=1, steps=0 → stay in IDLE. done pulses next cycle; coil and index are unchanged.
  - RUN:
    - Each cycle, divider += 1.
    - When divider == period_eff−1: divider ← 0, index advances, remaining −= 1.
    - If remaining was 1 on that edge: → IDLE and done ← 1 on the same edge.
  - RUN, stop=1 → IDLE on that edge. No step occurs that cycle, done is not pulsed, and remaining holds its value.
  - stop takes priority over a step falling due on the same edge.
- start while in RUN is ignored; stop while in IDLE is ignored.
- coil ← table[index] (post-alignment) in RUN and on the start edge.
- In IDLE, coil holds its last value if HOLD=1, else 0000.
- index persists across runs, so the motor position is not lost between commands.

## Timing
- Reset values: coil=0000, busy=0, done=0, remaining=0, index=0, divider=0, state IDLE.
- A reset asserted mid-run forces the reset values immediately; no done pulse is generated.
- Let start be accepted at edge t. Then:
  - busy=1 and coil=table[aligned index] from edge t.
  - Step k occurs at edge t + k·period_eff.
  - The last step (k=steps) occurs at edge t + steps·period_eff. busy falls and done rises on the same edge; done falls one cycle later.
- A new start is accepted in the cycle immediately after done.
- remaining always equals steps − steps_taken.
- Width rule: steps = 2^CNT_W−1 is legal. No overflow can occur, because the decrement happens only when the value is non-zero.

## Test plan
- Reset, then mode=1, dir=0, steps=4, period=3, start → coil 0011 at t; 0110@t+3, 1100@t+6, 1001@t+9, 0011@t+12; done pulse at t+12; busy low at t+12.
- mode=2, dir=1, steps=3, period=1, index=0 → coil 0001, 1001, 1000, 1100 on consecutive edges; remaining counts 3,2,1,0.
- mode=0 after a half-mode run ends at an odd index (e.g. 3) → alignment to index 2 (coil 0010) at start; steps then move 0100, 1000, 0001 (wrap).
- steps=5, period=10, stop asserted at the cycle of step 2's due edge → step 2 not taken; idle next; remaining=4; no done; coil=0000 with HOLD=0, or held at the step-1 pattern with HOLD=1.
- Edge cases:
  - steps=0 → no coil change, done pulses one cycle after start.
  - period=0 → behaves as period=1.
  - start asserted while busy → ignored, with remaining unaffected.
- Asynchronous reset mid-run → all outputs reach their reset values without waiting for clk; a subsequent start runs normally from index 0.
